store_commit_unit: RTL and testbench
====================================

// Module: store_commit_unit
// PURPOSE
//  Drain side of the store buffer. Takes the oldest buffer entry (slot 0), waits until it is resolved
//  and non-speculative, writes it to data RAM with a req/ready handshake, then reports the committed
//  addr/data on store_addr_active/store_data_active so the buffer invalidates and shifts out that entry.
//  Sits between store_buffer and the data RAM port; one store in flight at a time.
// PARAMETERS
//  ADDR_WIDTH  15  data RAM word-address width (32k RAM)
//  DATA_WIDTH  32  store data width
//  MAX_WAIT    64  cycles in WAIT_ACK before the sticky timeout error is raised
//  CNT_WIDTH   16  width of the committed-store counter
// PORTS
//  clk                 in   1           clock, all state on posedge
//  reset               in   1           synchronous, active-high
//  sb_head_valid       in   1           slot 0 VALID_ENTRY
//  sb_head_speculative in   1           slot 0 SPECULATIVE
//  sb_head_addr_tag    in   1           slot 0 ADDR_TAG (1 = address still a tag)
//  sb_head_data_tag    in   1           slot 0 DATA_TAG (1 = data still a tag)
//  sb_head_addr        in   64          slot 0 ADDR_SLOT (low ADDR_WIDTH bits used once resolved)
//  sb_head_data        in   64          slot 0 DATA_SLOT (low DATA_WIDTH bits used once resolved)
//  prediction_failed   in   1           branch squash; blocks a speculative head in that cycle
//  mem_wr_req          out  1           RAM write request
//  mem_addr            out  ADDR_WIDTH  RAM write address
//  mem_wdata           out  DATA_WIDTH  RAM write data
//  mem_ready           in   1           RAM accepts write in a cycle where mem_wr_req=1
//  store_addr_active   out  ADDR_WIDTH  committed address to the store buffer
//  store_data_active   out  DATA_WIDTH  committed data to the store buffer
//  commit_pulse        out  1           1-cycle strobe, high when *_active carry a real commit
//  commit_busy         out  1           high in ISSUE/WAIT_ACK/RETIRE/SETTLE
//  timeout_err         out  1           sticky; set on MAX_WAIT expiry, cleared only by reset
//  commit_count        out  CNT_WIDTH   stores committed since reset, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; mem_wr_req=0, mem_addr=0, mem_wdata=0, commit_pulse=0,
//   commit_busy=0, timeout_err=0, commit_count=0; store_addr_active/store_data_active = all-ones.
//  Idle value of *_active is all-ones (reserved; never a legal committed pair). Buffer compares these
//   every cycle, so they hold a real entry for exactly the RETIRE cycle only.
//  head_ready = sb_head_valid & !sb_head_addr_tag & !sb_head_data_tag & !sb_head_speculative
//   & !prediction_failed.
//  FSM states:
//   IDLE     if head_ready: latch addr/data into holding regs -> ISSUE; else stay.
//   ISSUE    mem_wr_req=1 with latched values; mem_ready=1 -> RETIRE; else -> WAIT_ACK,
//            wait counter cleared.
//   WAIT_ACK mem_wr_req held with stable addr/data; mem_ready -> RETIRE; counter increments;
//            counter==MAX_WAIT-1 sets timeout_err, and the request is still held.
//   RETIRE   mem_wr_req=0; *_active = latched pair; commit_pulse=1; commit_count+1 -> SETTLE.
//   SETTLE   *_active back to all-ones; one dead cycle so the buffer shift lands before slot 0 is
//            re-sampled -> IDLE.
//  Latency: head_ready to first mem_wr_req = 1 cycle; mem_ready to commit_pulse = 1 cycle;
//   min spacing between commits = 4 cycles.
//  Holding regs are written only in IDLE. Head changes after latch (squash, shift) are ignored.
//  A latched head is non-speculative, so prediction_failed in ISSUE or later is ignored.
//  Head whose VALID_ENTRY=0 (squashed, awaiting shift) is never committed.
//  Widths: addr = sb_head_addr[ADDR_WIDTH-1:0], data = sb_head_data[DATA_WIDTH-1:0]; upper bits ignored.
//  Reset mid-write: mem_wr_req drops the next edge; the RAM must tolerate the aborted request.
//   Buffer contents are reset in the same cycle.
//  mem_ready while mem_wr_req=0 is ignored.
// STRUCTURE
//  sb_pkg: shared slot field constants (VALID/SPEC/DATA/ADDR/TAG/IMM positions, SB_SLOT_WIDTH),
//   TAG_* field positions, and SC_IDLE..SC_SETTLE state encodings (3-bit localparams).
//  Single module, no sub-modules; the wait counter is inline (clog2(MAX_WAIT) bits).
// TESTING
//  1 Resolved non-spec head addr=0x0010, data=0xDEADBEEF, mem_ready=1 tied -> mem_wr_req 1 cycle later
//    with those values; commit_pulse 1 cycle after accept; *_active=0x0010/0xDEADBEEF that cycle only;
//    commit_count=1.
//  2 Head with data_tag=1 for 5 cycles, then 0 -> no mem_wr_req while tagged; write issues 1 cycle
//    after the tag clears.
//  3 Speculative head + prediction_failed=1 -> no write, commit_count unchanged; head then non-spec
//    valid -> normal commit.
//  4 mem_ready held low 3 cycles -> mem_addr/mem_wdata stable, mem_wr_req high throughout; commit on
//    4th; MAX_WAIT=4 with 10 low cycles -> timeout_err=1 and stays 1 after the commit.
//  5 Three back-to-back ready entries -> three commits spaced exactly 4 cycles, in order;
//    *_active all-ones between commits.
//  6 reset asserted in WAIT_ACK -> next cycle mem_wr_req=0, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : sb_pkg
//  Purpose   : Shared store-buffer definitions: slot field positions, tag
//              field positions and the store commit FSM state encodings.
//  Revision  : 1.0  initial release
// ============================================================================
package sb_pkg;

  // Store buffer slot layout (one slot = SB_SLOT_WIDTH bits)
  localparam int SB_VALID_POS    = 0;    // VALID_ENTRY
  localparam int SB_SPEC_POS     = 1;    // SPECULATIVE
  localparam int SB_ADDR_TAG_POS = 2;    // ADDR_TAG: address slot still holds a tag
  localparam int SB_DATA_TAG_POS = 3;    // DATA_TAG: data slot still holds a tag
  localparam int SB_IMM_POS      = 4;    // immediate-form store
  localparam int SB_ADDR_LSB     = 5;    // ADDR_SLOT
  localparam int SB_ADDR_MSB     = 68;
  localparam int SB_DATA_LSB     = 69;   // DATA_SLOT
  localparam int SB_DATA_MSB     = 132;
  localparam int SB_SLOT_WIDTH   = 133;

  // Tag field inside an unresolved ADDR_SLOT / DATA_SLOT
  localparam int TAG_LSB   = 0;
  localparam int TAG_MSB   = 5;
  localparam int TAG_WIDTH = TAG_MSB - TAG_LSB + 1;

  // Store commit FSM encodings
  localparam logic [2:0] SC_IDLE     = 3'd0;
  localparam logic [2:0] SC_ISSUE    = 3'd1;
  localparam logic [2:0] SC_WAIT_ACK = 3'd2;
  localparam logic [2:0] SC_RETIRE   = 3'd3;
  localparam logic [2:0] SC_SETTLE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = SC_IDLE,
    ST_ISSUE    = SC_ISSUE,
    ST_WAIT_ACK = SC_WAIT_ACK,
    ST_RETIRE   = SC_RETIRE,
    ST_SETTLE   = SC_SETTLE
  } sc_state_e;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/store_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module    : store_commit_unit
//  Purpose   : Drain side of the store buffer. Waits for slot 0 to be valid,
//              resolved and non-speculative, writes it to data RAM through a
//              req/ready handshake, then presents the committed addr/data
//              pair for exactly one cycle so the buffer drops that entry.
//              One store in flight at a time.
//  Ports     :
//    clk, reset                       clock, synchronous active-high reset
//    sb_head_*                        slot 0 fields from the store buffer
//    prediction_failed                branch squash (blocks speculative head)
//    mem_wr_req/mem_addr/mem_wdata    RAM write request and payload
//    mem_ready                        RAM accepts write when mem_wr_req=1
//    store_addr/data_active           committed pair (all-ones when idle)
//    commit_pulse                     one-cycle strobe for a real commit
//    commit_busy                      high while a store is being committed
//    timeout_err                      sticky RAM acknowledge timeout
//    commit_count                     committed stores, wraps
//  Revision  : 1.0  initial release
// ============================================================================
module store_commit_unit
  import sb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sb_head_valid,
  input  logic                  sb_head_speculative,
  input  logic                  sb_head_addr_tag,
  input  logic                  sb_head_data_tag,
  input  logic [63:0]           sb_head_addr,
  input  logic [63:0]           sb_head_data,
  input  logic                  prediction_failed,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] store_addr_active,
  output logic [DATA_WIDTH-1:0] store_data_active,
  output logic                  commit_pulse,
  output logic                  commit_busy,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  commit_count
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  sc_state_e state, state_nxt;

  logic                  head_ready;
  logic                  latch_en;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  timeout_q;
  logic [CNT_WIDTH-1:0]  count_q;

  // Upper slot bits are never used once the entry is resolved.
  logic unused_hi;
  assign unused_hi = ^{sb_head_addr[63:ADDR_WIDTH], sb_head_data[63:DATA_WIDTH]};

  assign head_ready = sb_head_valid & ~sb_head_addr_tag & ~sb_head_data_tag
                    & ~sb_head_speculative & ~prediction_failed;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. mem_ready only matters while a request is outstanding
  // (ISSUE / WAIT_ACK); elsewhere it is ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (head_ready) begin
          latch_en  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          accept    = 1'b1;
          state_nxt = ST_RETIRE;
        end else begin
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (mem_ready) begin
          accept    = 1'b1;
          state_nxt = ST_RETIRE;
        end
      end
      ST_RETIRE: state_nxt = ST_SETTLE;
      // Dead cycle: lets the buffer shift land before slot 0 is sampled again.
      ST_SETTLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: holding registers, wait counter, timeout flag, commit counter.
  // Holding registers load only in IDLE, so any later change of the head
  // (squash, shift) cannot disturb the write in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_addr <= '0;
      hold_data <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (latch_en) begin
        hold_addr <= sb_head_addr[ADDR_WIDTH-1:0];
        hold_data <= sb_head_data[DATA_WIDTH-1:0];
      end

      // Counter saturates at its last value so the flag cannot re-trigger.
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT_ACK && wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (state == ST_WAIT_ACK && wait_cnt == WAIT_LAST) begin
        timeout_q <= 1'b1;
      end

      // Counted on acceptance so the new total is visible with commit_pulse.
      if (accept) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only.
  // --------------------------------------------------------------------------
  assign mem_wr_req        = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
  assign mem_addr          = hold_addr;
  assign mem_wdata         = hold_data;
  assign commit_pulse      = (state == ST_RETIRE);
  assign commit_busy       = (state != ST_IDLE);
  // All-ones is reserved and never a committed pair, so the buffer can
  // compare every cycle without a qualifier.
  assign store_addr_active = (state == ST_RETIRE) ? hold_addr : '1;
  assign store_data_active = (state == ST_RETIRE) ? hold_data : '1;
  assign timeout_err       = timeout_q;
  assign commit_count      = count_q;

endmodule : store_commit_unit
`default_nettype wire

// File: tb/tb_store_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module    : tb_store_commit_unit
//  Purpose   : Self-checking bench for store_commit_unit (MAX_WAIT=4).
//              Table of per-cycle vectors plus hand-written multi-cycle cases.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_store_commit_unit;

  localparam logic [14:0] AO = 15'h7FFF;
  localparam logic [31:0] DO = 32'hFFFF_FFFF;

  localparam logic [63:0] A1 = 64'hFFFF_0000_0000_0010;
  localparam logic [63:0] D1 = 64'h1234_5678_DEAD_BEEF;
  localparam logic [63:0] A2 = 64'h0000_0000_8000_0123;
  localparam logic [63:0] D2 = 64'hFFFF_FFFF_0BAD_F00D;
  localparam logic [63:0] A3 = 64'h0000_0000_0000_7FFE;
  localparam logic [63:0] D3 = 64'h0000_0000_0000_0001;
  localparam logic [14:0] MA1 = 15'h0010;
  localparam logic [31:0] MD1 = 32'hDEAD_BEEF;
  localparam logic [14:0] MA2 = 15'h0123;
  localparam logic [31:0] MD2 = 32'h0BAD_F00D;
  localparam logic [14:0] MA3 = 15'h7FFE;
  localparam logic [31:0] MD3 = 32'h0000_0001;

  logic        clk;
  logic        reset;
  logic        sb_head_valid;
  logic        sb_head_speculative;
  logic        sb_head_addr_tag;
  logic        sb_head_data_tag;
  logic [63:0] sb_head_addr;
  logic [63:0] sb_head_data;
  logic        prediction_failed;
  logic        mem_wr_req;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [14:0] store_addr_active;
  logic [31:0] store_data_active;
  logic        commit_pulse;
  logic        commit_busy;
  logic        timeout_err;
  logic [15:0] commit_count;

  store_commit_unit #(
    .ADDR_WIDTH(15), .DATA_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .sb_head_valid      (sb_head_valid),
    .sb_head_speculative(sb_head_speculative),
    .sb_head_addr_tag   (sb_head_addr_tag),
    .sb_head_data_tag   (sb_head_data_tag),
    .sb_head_addr       (sb_head_addr),
    .sb_head_data       (sb_head_data),
    .prediction_failed  (prediction_failed),
    .mem_wr_req         (mem_wr_req),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ready          (mem_ready),
    .store_addr_active  (store_addr_active),
    .store_data_active  (store_data_active),
    .commit_pulse       (commit_pulse),
    .commit_busy        (commit_busy),
    .timeout_err        (timeout_err),
    .commit_count       (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld, spec, atag, dtag, pf, rdy;
    logic [63:0] a, d;
    logic        e_req, e_pulse, e_busy;
    logic [14:0] e_maddr;
    logic [31:0] e_mdata;
    logic [14:0] e_aa;
    logic [31:0] e_ad;
    logic [15:0] e_cnt;
    logic        e_to;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_vec;
  int n_err;

  function automatic vec_t mk(
    input logic rst, vld, spec, atag, dtag, pf, rdy,
    input logic [63:0] a, d,
    input logic e_req, e_pulse, e_busy,
    input logic [14:0] e_maddr, input logic [31:0] e_mdata,
    input logic [14:0] e_aa, input logic [31:0] e_ad,
    input logic [15:0] e_cnt, input logic e_to);
    vec_t v;
    v.rst = rst; v.vld = vld; v.spec = spec; v.atag = atag; v.dtag = dtag;
    v.pf = pf; v.rdy = rdy; v.a = a; v.d = d;
    v.e_req = e_req; v.e_pulse = e_pulse; v.e_busy = e_busy;
    v.e_maddr = e_maddr; v.e_mdata = e_mdata; v.e_aa = e_aa; v.e_ad = e_ad;
    v.e_cnt = e_cnt; v.e_to = e_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, vld, spec, atag, dtag, pf, rdy,
                       input logic [63:0] a, d);
    reset = rst; sb_head_valid = vld; sb_head_speculative = spec;
    sb_head_addr_tag = atag; sb_head_data_tag = dtag; prediction_failed = pf;
    mem_ready = rdy; sb_head_addr = a; sb_head_data = d;
  endtask

  // Advance one edge and sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".req"},   64'(mem_wr_req),        64'(v.e_req));
    chk({tag, ".pulse"}, 64'(commit_pulse),      64'(v.e_pulse));
    chk({tag, ".busy"},  64'(commit_busy),       64'(v.e_busy));
    chk({tag, ".maddr"}, 64'(mem_addr),          64'(v.e_maddr));
    chk({tag, ".mdata"}, 64'(mem_wdata),         64'(v.e_mdata));
    chk({tag, ".aa"},    64'(store_addr_active), 64'(v.e_aa));
    chk({tag, ".ad"},    64'(store_data_active), 64'(v.e_ad));
    chk({tag, ".cnt"},   64'(commit_count),      64'(v.e_cnt));
    chk({tag, ".to"},    64'(timeout_err),       64'(v.e_to));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);

    //              rst vld spc at dt pf rdy  a   d  | req pls bsy maddr mdata aa  ad  cnt to
    // reset
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 0, 0, 0, 15'd0, 32'd0, AO, DO, 16'd0, 0);
    // basic commit, mem_ready tied high
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 1, A1, D1,       1, 0, 1, MA1, MD1, AO,  DO,  16'd0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 1, A1, D1,       0, 1, 1, MA1, MD1, MA1, MD1, 16'd1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 1, MA1, MD1, AO,  DO,  16'd1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 0, MA1, MD1, AO,  DO,  16'd1, 0);
    // data tag held 5 cycles
    for (int i = 5; i < 10; i++)
      vecs[i] = mk(0, 1, 0, 0, 1, 0, 1, A2, D2,      0, 0, 0, MA1, MD1, AO,  DO,  16'd1, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 0, 1, A2, D2,       1, 0, 1, MA2, MD2, AO,  DO,  16'd1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 1, A2, D2,       0, 1, 1, MA2, MD2, MA2, MD2, 16'd2, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 1, MA2, MD2, AO,  DO,  16'd2, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    // blocked heads: spec+squash, spec, squash alone, addr tag, invalid
    vecs[14] = mk(0, 1, 1, 0, 0, 1, 1, A3, D3,       0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    vecs[15] = mk(0, 1, 1, 0, 0, 0, 1, A3, D3,       0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    vecs[16] = mk(0, 1, 0, 0, 0, 1, 1, A3, D3,       0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    vecs[17] = mk(0, 1, 0, 1, 0, 0, 1, A3, D3,       0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, A3, D3,       0, 0, 0, MA2, MD2, AO,  DO,  16'd2, 0);
    // now commits; head change and squash after latch are ignored
    vecs[19] = mk(0, 1, 0, 0, 0, 0, 1, A3, D3,       1, 0, 1, MA3, MD3, AO,  DO,  16'd2, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 1, 1, A1, D1,       0, 1, 1, MA3, MD3, MA3, MD3, 16'd3, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 1, MA3, MD3, AO,  DO,  16'd3, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0, 0, 0, 0, MA3, MD3, AO,  DO,  16'd3, 0);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].spec, vecs[i].atag, vecs[i].dtag,
            vecs[i].pf, vecs[i].rdy, vecs[i].a, vecs[i].d);
      tick();
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // ---- stall: ready low for 3 request cycles, accepted on the 4th ----
    drive(0, 1, 0, 0, 0, 0, 0, 64'h0042, 64'hCAFE_F00D);
    tick();
    chk("stall.issue_req", 64'(mem_wr_req), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 1, 0, 64'h1111, 64'h2222);   // head disturbed, must be ignored
      tick();
      chk($sformatf("stall%0d.req", i),   64'(mem_wr_req),   64'd1);
      chk($sformatf("stall%0d.addr", i),  64'(mem_addr),     64'h0042);
      chk($sformatf("stall%0d.data", i),  64'(mem_wdata),    64'hCAFE_F00D);
      chk($sformatf("stall%0d.pulse", i), 64'(commit_pulse), 64'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    tick();
    chk("stall.pulse", 64'(commit_pulse),      64'd1);
    chk("stall.aa",    64'(store_addr_active), 64'h0042);
    chk("stall.ad",    64'(store_data_active), 64'hCAFE_F00D);
    chk("stall.cnt",   64'(commit_count),      64'd4);
    chk("stall.to",    64'(timeout_err),       64'd0);
    tick();
    tick();
    chk("stall.idle", 64'(commit_busy), 64'd0);

    // ---- timeout: ready low for 10 request cycles with MAX_WAIT=4 ----
    drive(0, 1, 0, 0, 0, 0, 0, 64'h0077, 64'h0000_7777);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("tmo%0d.req", i), 64'(mem_wr_req),  64'd1);
      chk($sformatf("tmo%0d.to", i),  64'(timeout_err), (i >= 4) ? 64'd1 : 64'd0);
    end
    mem_ready = 1'b1;
    tick();
    chk("tmo.pulse", 64'(commit_pulse), 64'd1);
    chk("tmo.aa",    64'(store_addr_active), 64'h0077);
    chk("tmo.cnt",   64'(commit_count), 64'd5);
    tick();
    tick();
    chk("tmo.sticky", 64'(timeout_err), 64'd1);
    chk("tmo.idle",   64'(commit_busy), 64'd0);

    // ---- back-to-back: three ready entries, buffer shifts on each commit ----
    begin
      logic [14:0] qa [$];
      logic [31:0] qd [$];
      logic [14:0] ea [3];
      logic [31:0] ed [3];
      int k;
      int last;
      ea[0] = 15'h0100; ea[1] = 15'h0200; ea[2] = 15'h0300;
      ed[0] = 32'h1111_1111; ed[1] = 32'h2222_2222; ed[2] = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
        qa.push_back(ea[i]);
        qd.push_back(ed[i]);
      end
      k = 0;
      last = -1;
      for (int c = 0; c < 16; c++) begin
        if (qa.size() > 0) drive(0, 1, 0, 0, 0, 0, 1, 64'(qa[0]), 64'(qd[0]));
        else               drive(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
        tick();
        if (commit_pulse) begin
          if (k < 3) begin
            chk($sformatf("b2b%0d.aa", k),  64'(store_addr_active), 64'(ea[k]));
            chk($sformatf("b2b%0d.ad", k),  64'(store_data_active), 64'(ed[k]));
            chk($sformatf("b2b%0d.cnt", k), 64'(commit_count),      64'(6 + k));
            if (last >= 0) chk($sformatf("b2b%0d.gap", k), 64'(c - last), 64'd4);
          end
          last = c;
          k++;
          if (qa.size() > 0) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
          end
        end else if (last >= 0 && k < 3) begin
          chk($sformatf("b2b.c%0d.aa_idle", c), 64'(store_addr_active), 64'(AO));
          chk($sformatf("b2b.c%0d.ad_idle", c), 64'(store_data_active), 64'(DO));
        end
      end
      chk("b2b.commits", 64'(k), 64'd3);
    end

    // ---- reset asserted while waiting for ready ----
    drive(0, 1, 0, 0, 0, 0, 0, 64'h0055, 64'h0000_5555);
    tick();
    tick();
    chk("rst.pre_req",  64'(mem_wr_req),  64'd1);
    chk("rst.pre_busy", 64'(commit_busy), 64'd1);
    drive(1, 1, 0, 0, 0, 0, 0, 64'h0055, 64'h0000_5555);
    tick();
    chk_all("rst", mk(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0,
                      0, 0, 0, 15'd0, 32'd0, AO, DO, 16'd0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    tick();
    chk("rst.idle_req",  64'(mem_wr_req),  64'd0);
    chk("rst.idle_busy", 64'(commit_busy), 64'd0);
    drive(0, 1, 0, 0, 0, 0, 1, 64'h0066, 64'h0000_6666);
    tick();
    chk("rst.restart_req",  64'(mem_wr_req), 64'd1);
    chk("rst.restart_addr", 64'(mem_addr),   64'h0066);
    drive(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    tick();
    chk("rst.restart_cnt", 64'(commit_count), 64'd1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_store_commit_unit
`default_nettype wire
